parity_rx_serial: RTL and testbench

- Serial receiver end of the team's XOR-parity link. It deserialises a framed bit stream: start bit, DATA_W data bits LSB first, parity bit, stop bit.
- Accumulates a running XOR over the data bits and checks it against the received parity bit.
- Presents the word with parity and framing status for one cycle.
- Sits downstream of the parity transmitter and XOR-based parity generator blocks.

---
 rtl/parity_rx_serial_if.sv | 23 ++
 rtl/parity_rx_serial.sv | 74 +++++++
 tb/tb_parity_rx_serial.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/parity_rx_serial_if.sv
// Serial bit link into the parity receiver plus its word/status result.
// The bit source is the master and the receiver is the slave.
interface parity_rx_serial_if #(
    parameter int DATA_W = 8
);
    logic              bit_in;
    logic              bit_valid;
    logic              busy;
    logic [DATA_W-1:0] data_out;
    logic              done;
    logic              parity_err;
    logic              frame_err;

    modport master (
        output bit_in, bit_valid,
        input  busy, data_out, done, parity_err, frame_err
    );

    modport slave (
        input  bit_in, bit_valid,
        output busy, data_out, done, parity_err, frame_err
    );
endinterface

// File: rtl/parity_rx_serial.sv
// Deserialises start / DATA_W data bits (LSB first) / parity / stop frames and
// reports the word with parity and framing status on a one-cycle done pulse.
module parity_rx_serial #(
    parameter int DATA_W  = 8,
    parameter int ODD_PAR = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    parity_rx_serial_if.slave   link
);
    localparam int   CNT_W   = $clog2(DATA_W) + 1;
    localparam logic ODD_BIT = (ODD_PAR != 0);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              acc;
    logic              par_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            shreg           <= '0;
            cnt             <= '0;
            acc             <= 1'b0;
            par_ok          <= 1'b0;
            link.busy       <= 1'b0;
            link.data_out   <= '0;
            link.done       <= 1'b0;
            link.parity_err <= 1'b0;
            link.frame_err  <= 1'b0;
        end else begin
            link.done <= 1'b0;
            if (link.bit_valid) begin
                case (state)
                    IDLE: begin
                        // A 0 on an idle line is the start bit.
                        if (!link.bit_in) begin
                            state     <= DATA;
                            cnt       <= '0;
                            shreg     <= '0;
                            acc       <= 1'b0;
                            link.busy <= 1'b1;
                        end
                    end
                    DATA: begin
                        for (int i = 0; i < DATA_W; i++) begin
                            if (cnt == CNT_W'(i)) shreg[i] <= link.bit_in;
                        end
                        acc <= acc ^ link.bit_in;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DATA_W - 1)) state <= PARITY;
                    end
                    PARITY: begin
                        par_ok <= ((acc ^ link.bit_in) == ODD_BIT);
                        state  <= STOP;
                    end
                    STOP: begin
                        // A bad stop bit is reported, not resynchronised.
                        link.data_out   <= shreg;
                        link.parity_err <= !par_ok;
                        link.frame_err  <= !link.bit_in;
                        link.done       <= 1'b1;
                        link.busy       <= 1'b0;
                        state           <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_parity_rx_serial.sv
// Drives identical random and directed frames into an even- and an odd-parity
// receiver; a queue of expected words per receiver is drained by monitors.
module tb_parity_rx_serial;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic bit_in = 1'b1;
    logic bit_valid = 1'b0;

    always #5 clk = ~clk;

    parity_rx_serial_if #(.DATA_W(DW)) ife ();
    parity_rx_serial_if #(.DATA_W(DW)) ifo ();

    assign ife.bit_in    = bit_in;
    assign ife.bit_valid = bit_valid;
    assign ifo.bit_in    = bit_in;
    assign ifo.bit_valid = bit_valid;

    parity_rx_serial #(.DATA_W(DW), .ODD_PAR(0)) dut_even (
        .clk(clk), .reset_n(reset_n), .link(ife.slave));
    parity_rx_serial #(.DATA_W(DW), .ODD_PAR(1)) dut_odd (
        .clk(clk), .reset_n(reset_n), .link(ifo.slave));

    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
    } exp_t;

    exp_t q_e[$];
    exp_t q_o[$];
    exp_t xe, xo;
    int nchk = 0;
    int npass = 0;
    logic [DW-1:0] last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act === req) npass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    // Reference: parity error when the 1-count of data+parity has the wrong parity.
    task automatic expect_frame(input logic [DW-1:0] d, input logic par, input logic stop);
        int ones;
        ones = $countones(d) + int'(par);
        q_e.push_back('{d, (ones % 2) != 0, !stop});
        q_o.push_back('{d, (ones % 2) != 1, !stop});
    endtask

    task automatic drive(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        bit_in    = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop,
                              input int maxgap);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        bits.push_back(par);
        bits.push_back(stop);
        expect_frame(d, par, stop);
        foreach (bits[i]) begin
            drive(bits[i]);
            if (i == bits.size() - 1) begin
                chk("done_latency", {31'd0, ife.done}, 32'd1);
                chk("busy_fall", {31'd0, ife.busy}, 32'd0);
                chk("done_latency_odd", {31'd0, ifo.done}, 32'd1);
            end else begin
                repeat ($urandom_range(0, maxgap)) begin
                    @(posedge clk);
                    #1;
                    chk("gap_busy", {31'd0, ife.busy}, 32'd1);
                    chk("gap_hold", {24'd0, ife.data_out}, {24'd0, last_data});
                end
            end
        end
        last_data = d;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, ife.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, ife.done}, 32'd0);
        chk({tag, "_data"}, {24'd0, ife.data_out}, 32'd0);
        chk({tag, "_perr"}, {31'd0, ife.parity_err}, 32'd0);
        chk({tag, "_ferr"}, {31'd0, ife.frame_err}, 32'd0);
        chk({tag, "_odd_busy"}, {31'd0, ifo.busy}, 32'd0);
        chk({tag, "_odd_data"}, {24'd0, ifo.data_out}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (ife.done === 1'b1) begin
            if (q_e.size() == 0) begin
                nchk++;
                $display("FAIL unexpected_done_even actual=done required=no_pending_frame at %0t", $time);
            end else begin
                xe = q_e.pop_front();
                chk("data_even", {24'd0, ife.data_out}, {24'd0, xe.data});
                chk("perr_even", {31'd0, ife.parity_err}, {31'd0, xe.perr});
                chk("ferr_even", {31'd0, ife.frame_err}, {31'd0, xe.ferr});
            end
        end
    end

    always @(negedge clk) begin
        if (ifo.done === 1'b1) begin
            if (q_o.size() == 0) begin
                nchk++;
                $display("FAIL unexpected_done_odd actual=done required=no_pending_frame at %0t", $time);
            end else begin
                xo = q_o.pop_front();
                chk("data_odd", {24'd0, ifo.data_out}, {24'd0, xo.data});
                chk("perr_odd", {31'd0, ifo.parity_err}, {31'd0, xo.perr});
                chk("ferr_odd", {31'd0, ifo.frame_err}, {31'd0, xo.ferr});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] d;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("por");
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted while the line is idle and valid.
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("mid_reset");
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1);
            chk("idle_busy", {31'd0, ife.busy}, 32'd0);
            chk("idle_done", {31'd0, ife.done}, 32'd0);
        end

        send_frame(8'hA5, 1'b0, 1'b1, 0);
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        send_frame(8'h01, 1'b1, 1'b1, 0);
        send_frame(8'hFF, 1'b0, 1'b1, 3);

        // Partial frame killed by reset must not produce a done.
        drive(1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1);
        reset_n = 1'b0;
        #1 chk_reset_outputs("frame_reset");
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1 chk("post_reset_busy", {31'd0, ife.busy}, 32'd0);
        last_data = '0;

        send_frame(8'h07, 1'b0, 1'b1, 0);
        send_frame(8'h07, 1'b1, 1'b1, 0);

        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 2)) drive(1'b1);
            d = DW'($urandom);
            send_frame(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
                       int'($urandom_range(0, 3)));
        end

        bit_valid = 1'b0;
        for (int i = 0; i < 20 && (q_e.size() != 0 || q_o.size() != 0); i++) @(posedge clk);
        #1;
        chk("drain_even", q_e.size(), 32'd0);
        chk("drain_odd", q_o.size(), 32'd0);
        chk("final_done", {31'd0, ife.done}, 32'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
